// File: rtl/hyp_isqrt_if.sv
// Handshake bundle for hyp_isqrt: radicand in over valid/ready, root/remainder out over valid/ready.
interface hyp_isqrt_if #(
    parameter int IN_W  = 17,
    parameter int OUT_W = (IN_W + 1) / 2
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  radicand;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] root;
    logic [OUT_W:0]   rem;

    modport master (
        output in_valid, radicand, out_ready,
        input  in_ready, out_valid, root, rem
    );

    modport slave (
        input  in_valid, radicand, out_ready,
        output in_ready, out_valid, root, rem
    );
endinterface

// File: rtl/hyp_isqrt.sv
// Sequential digit-by-digit integer square root, one root bit per clock.
// Define HYP_ISQRT_ROUND_EN to round the root to nearest (remainder stays truncated).
module hyp_isqrt #(
    parameter int IN_W  = 17,
    parameter int OUT_W = (IN_W + 1) / 2
) (
    input logic        clk,
    input logic        rst,
    hyp_isqrt_if.slave bus
);
    localparam int X_W   = 2 * OUT_W;
    localparam int R_W   = OUT_W + 2;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [X_W-1:0]   x_q;
    logic [R_W-1:0]   r_q;
    logic [OUT_W-1:0] q_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] root_q;
    logic [OUT_W:0]   rem_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [R_W-1:0]   r_shift;
    logic [R_W-1:0]   trial;
    logic [R_W-1:0]   r_d;
    logic [OUT_W-1:0] q_d;
    logic [OUT_W-1:0] root_d;
    logic             fits;

    always_comb begin
        r_shift = {r_q[R_W-3:0], x_q[X_W-1 -: 2]};
        trial   = {q_q, 2'b01};
        fits    = (r_shift >= trial);
        r_d     = fits ? (r_shift - trial) : r_shift;
        q_d     = (q_q << 1) | OUT_W'(fits);
        root_d  = q_d;
`ifdef HYP_ISQRT_ROUND_EN
        // Round up when x lies past the midpoint (s+0.5)^2, i.e. rem > s; saturate at all-ones.
        if ((r_d > R_W'(q_d)) && (q_d != '1)) begin
            root_d = q_d + OUT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (bus.in_valid) begin
                        x_q        <= X_W'(bus.radicand);
                        r_q        <= '0;
                        q_q        <= '0;
                        cnt_q      <= CNT_W'(OUT_W - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    x_q   <= x_q << 2;
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        root_q      <= root_d;
                        rem_q       <= r_d[OUT_W:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.root      = root_q;
    assign bus.rem       = rem_q;
endmodule

// File: tb/tb_hyp_isqrt.sv
// Self-checking bench for hyp_isqrt: cycle-level behavioural model plus directed and random traffic.
module tb_hyp_isqrt;
    localparam int IN_W  = 17;
    localparam int OUT_W = 9;
    localparam int XMAX  = 131071;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hyp_isqrt_if #(.IN_W(IN_W)) bus ();
    hyp_isqrt #(.IN_W(IN_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint fsqrt(input longint x);
        longint s = 0;
        while ((s + 1) * (s + 1) <= x) s++;
        return s;
    endfunction

    function automatic longint exp_root(input longint x);
        longint s = fsqrt(x);
`ifdef HYP_ISQRT_ROUND_EN
        if ((x - s * s > s) && (s != (1 << OUT_W) - 1)) s++;
`endif
        return s;
    endfunction

    function automatic longint exp_rem(input longint x);
        longint s = fsqrt(x);
        return x - s * s;
    endfunction

    // Timing model: ready after reset/handshake, result OUT_W edges after accept, held until taken.
    bit     m_ready = 1'b0;
    bit     m_valid = 1'b0;
    longint m_root  = 0;
    longint m_rem   = 0;
    longint m_x     = 0;
    int     m_wait  = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ready = 1'b0; m_valid = 1'b0; m_root = 0; m_rem = 0; m_wait = 0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_root  = exp_root(m_x);
                m_rem   = exp_rem(m_x);
            end
        end else if (m_valid) begin
            if (bus.out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_ready) begin
            if (bus.in_valid) begin
                m_ready = 1'b0;
                m_x     = longint'(bus.radicand);
                m_wait  = OUT_W;
            end
        end else begin
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model in_ready", bus.in_ready, m_ready);
            chk("model out_valid", bus.out_valid, m_valid);
            chk("model root", bus.root, m_root);
            chk("model rem", bus.rem, m_rem);
        end
    end

    task automatic send(input int x, input bit hold);
        bit rdy;
        int n = 0;
        bus.in_valid = 1'b1;
        bus.radicand = IN_W'(x);
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("accept timeout", 0, 1);
        acc_cyc = cyc;
        if (!hold) bus.in_valid = 1'b0;
        bus.radicand = IN_W'($urandom_range(0, XMAX));
    endtask

    task automatic recv(input string name, input int er, input int erem, input int bp, input bit poke);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 200);
        if (!bus.out_valid) begin
            chk({name, " valid timeout"}, 0, 1);
            return;
        end
        chk({name, " latency"}, cyc - acc_cyc, OUT_W);
        chk({name, " root"}, bus.root, er);
        chk({name, " rem"}, bus.rem, erem);
        for (int i = 0; i < bp; i++) begin
            if (poke) bus.in_valid = ~bus.in_valid;
            @(negedge clk);
            chk({name, " held valid"}, bus.out_valid, 1);
            chk({name, " held root"}, bus.root, er);
            chk({name, " held rem"}, bus.rem, erem);
            chk({name, " held in_ready"}, bus.in_ready, 0);
        end
        if (poke) bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, " ready after handshake"}, bus.in_ready, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int x;
        bus.in_valid  = 1'b0;
        bus.radicand  = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;

        chk("pin sqrt 169", fsqrt(169), 13);
        chk("pin rem 130050", exp_rem(130050), 450);
        chk("pin rem 131071", exp_rem(131071), 27);
        chk("pin sqrt 26", fsqrt(26), 5);

        chk("reset in_ready", bus.in_ready, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset root", bus.root, 0);
        chk("reset rem", bus.rem, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready after reset", bus.in_ready, 1);

        send(25, 1'b0);  recv("r25", 5, 0, 0, 1'b0);
        send(169, 1'b0); recv("r169", 13, 0, 0, 1'b0);
        send(100, 1'b0); recv("r100", 10, 0, 0, 1'b0);
`ifdef HYP_ISQRT_ROUND_EN
        send(130050, 1'b0); recv("r130050", 361, 450, 0, 1'b0);
`else
        send(130050, 1'b0); recv("r130050", 360, 450, 0, 1'b0);
`endif
        send(131071, 1'b0); recv("r131071", 362, 27, 0, 1'b0);
        send(0, 1'b0);      recv("r0", 0, 0, 0, 1'b0);

        send(26, 1'b0);     recv("bp26", 5, 1, 5, 1'b1);

        send(169, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort out_valid", bus.out_valid, 0);
        chk("abort root", bus.root, 0);
        chk("abort rem", bus.rem, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort in_ready", bus.in_ready, 1);
        send(25, 1'b0);     recv("post-abort 25", 5, 0, 0, 1'b0);

        send(9, 1'b1);      recv("b2b 9", 3, 0, 0, 1'b0);
        send(16, 1'b1);     recv("b2b 16", 4, 0, 0, 1'b0);
        send(49, 1'b0);     recv("b2b 49", 7, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: x = XMAX;
                1: x = $urandom_range(0, 3);
                default: x = $urandom_range(0, XMAX);
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(x, 1'b0);
            recv("random", int'(exp_root(x)), int'(exp_rem(x)), $urandom_range(0, 3), 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
